// File: rtl/sd_seq_gen.sv
// Throttled sequence-number generator: emits {tag, seq} words on a valid/ready
// handshake, gating p_srdy with a rotating pattern sampled at the start of each run.
module sd_seq_gen #(
  parameter int unsigned width   = 8,
  parameter int unsigned tag_sz  = 1,
  parameter int unsigned tag_val = 0,
  parameter int unsigned pat_dep = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        num_items,
  input  logic [pat_dep-1:0] srdy_pat,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data,
  output logic               busy,
  output logic               done
);

  localparam int unsigned COUNT_SZ = width - tag_sz;
  localparam int unsigned PTR_W    = (pat_dep > 1) ? $clog2(pat_dep) : 1;
  localparam logic [tag_sz-1:0] TAG      = tag_sz'(tag_val);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(pat_dep - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [COUNT_SZ-1:0] r_seq;
  logic [15:0]         r_remaining;
  logic [pat_dep-1:0]  r_pat;
  logic [PTR_W-1:0]    r_ptr;
  logic                r_srdy;
  logic                r_busy;
  logic                r_done;

  logic                w_xfer;
  logic                w_hold;
  logic [PTR_W-1:0]    w_ptr_adv;
  logic [15:0]         w_rem_after;
  logic [pat_dep-1:0]  w_start_pat;

  logic [COUNT_SZ-1:0] w_seq_d;
  logic [15:0]         w_rem_d;
  logic [pat_dep-1:0]  w_pat_d;
  logic [PTR_W-1:0]    w_ptr_d;
  logic                w_srdy_d;
  logic                w_busy_d;
  logic                w_done_d;

  assign w_xfer      = r_srdy & p_drdy;
  assign w_hold      = r_srdy & ~p_drdy;
  assign w_ptr_adv   = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
  assign w_rem_after = r_remaining - 16'(w_xfer);
  // An all-zero pattern would stall forever, so it is promoted to full rate.
  assign w_start_pat = (srdy_pat == '0) ? '1 : srdy_pat;

  assign p_srdy = r_srdy;
  assign p_data = {TAG, r_seq};
  assign busy   = r_busy;
  assign done   = r_done;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = (num_items != 16'd0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (w_xfer && (w_rem_after == 16'd0)) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    w_seq_d  = r_seq + COUNT_SZ'(w_xfer);
    w_rem_d  = r_remaining;
    w_pat_d  = r_pat;
    w_ptr_d  = r_ptr;
    w_srdy_d = 1'b0;
    w_busy_d = (w_next_state == S_RUN);
    w_done_d = (w_next_state == S_DONE);
    case (r_state)
      S_IDLE: begin
        if (start && (num_items != 16'd0)) begin
          w_rem_d  = num_items;
          w_pat_d  = w_start_pat;
          w_ptr_d  = '0;
          w_srdy_d = w_start_pat[0];
        end
      end
      S_RUN: begin
        // A stalled word keeps its slot; the pattern only advances when not held.
        if (w_hold) begin
          w_srdy_d = 1'b1;
        end else begin
          w_ptr_d  = w_ptr_adv;
          w_rem_d  = w_rem_after;
          w_srdy_d = (w_rem_after != 16'd0) ? r_pat[w_ptr_adv] : 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq       <= '0;
      r_remaining <= '0;
      r_pat       <= '1;
      r_ptr       <= '0;
      r_srdy      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_seq       <= w_seq_d;
      r_remaining <= w_rem_d;
      r_pat       <= w_pat_d;
      r_ptr       <= w_ptr_d;
      r_srdy      <= w_srdy_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
    end
  end

endmodule

// File: tb/tb_sd_seq_gen.sv
// Directed bench for sd_seq_gen: per-cycle vector table plus hand-written
// sequences for stalls, reset mid-run, ignored start and tagged sequence wrap.
module tb_sd_seq_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, p_drdy;
  logic [15:0] num_items;
  logic [7:0]  srdy_pat;
  logic        p_srdy, busy, done;
  logic [7:0]  p_data;

  logic        t_reset, t_start, t_p_drdy;
  logic [15:0] t_num_items;
  logic [7:0]  t_srdy_pat;
  logic        t_p_srdy, t_busy, t_done;
  logic [7:0]  t_p_data;

  sd_seq_gen #(.width(8), .tag_sz(1), .tag_val(0), .pat_dep(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_items(num_items),
    .srdy_pat(srdy_pat), .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
    .busy(busy), .done(done)
  );

  sd_seq_gen #(.width(8), .tag_sz(1), .tag_val(1), .pat_dep(8)) dut_tag (
    .clk(clk), .reset(t_reset), .start(t_start), .num_items(t_num_items),
    .srdy_pat(t_srdy_pat), .p_srdy(t_p_srdy), .p_drdy(t_p_drdy), .p_data(t_p_data),
    .busy(t_busy), .done(t_done)
  );

  typedef struct {
    logic        rst;
    logic        st;
    logic [15:0] n;
    logic [7:0]  pat;
    logic        drdy;
    logic        e_srdy;
    logic        e_busy;
    logic        e_done;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t v(logic rst, logic st, logic [15:0] n, logic [7:0] pat,
                             logic drdy, logic es, logic eb, logic ed, logic [7:0] edata);
    vec_t r;
    r.rst = rst; r.st = st; r.n = n; r.pat = pat; r.drdy = drdy;
    r.e_srdy = es; r.e_busy = eb; r.e_done = ed; r.e_data = edata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive main-instance inputs, then advance to the next falling edge.
  task automatic apply(input logic rst, input logic st, input logic [15:0] n,
                       input logic [7:0] pat, input logic drdy);
    reset = rst; start = st; num_items = n; srdy_pat = pat; p_drdy = drdy;
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic es, input logic eb,
                         input logic ed, input logic [7:0] edata);
    chk({name, ".srdy"}, 32'(p_srdy), 32'(es));
    chk({name, ".busy"}, 32'(busy),   32'(eb));
    chk({name, ".done"}, 32'(done),   32'(ed));
    chk({name, ".data"}, 32'(p_data), 32'(edata));
  endtask

  initial begin
    int k;
    int done_cnt;
    reset = 1'b1; start = 1'b0; num_items = '0; srdy_pat = 8'hFF; p_drdy = 1'b1;
    t_reset = 1'b1; t_start = 1'b0; t_num_items = '0; t_srdy_pat = 8'hFF; t_p_drdy = 1'b1;

    // Reset, then 4 words at full rate
    tbl.push_back(v(1, 0, 0, 8'hFF, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 4, 8'hFF, 1, 1, 1, 0, 8'h00));
    tbl.push_back(v(0, 0, 0, 8'hFF, 1, 1, 1, 0, 8'h01));
    tbl.push_back(v(0, 0, 0, 8'hFF, 1, 1, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'hFF, 1, 1, 1, 0, 8'h03));
    tbl.push_back(v(0, 0, 0, 8'hFF, 1, 0, 0, 1, 8'h04));
    tbl.push_back(v(0, 0, 0, 8'hFF, 1, 0, 0, 0, 8'h04));
    // Pattern 0101: slots 0 and 2 only, wrapping through the 8-slot pattern
    tbl.push_back(v(1, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00));
    tbl.push_back(v(0, 1, 3, 8'h05, 1, 1, 1, 0, 8'h00));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h01));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h01));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h02));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h03));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h03));
    // All-zero pattern behaves as all ones; seq continues across runs
    tbl.push_back(v(0, 1, 2, 8'h00, 1, 1, 1, 0, 8'h03));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h04));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 0, 1, 8'h05));
    tbl.push_back(v(0, 0, 0, 8'h00, 1, 0, 0, 0, 8'h05));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].n, tbl[i].pat, tbl[i].drdy);
      if (i == 0) t_reset = 1'b0;
      chk_out($sformatf("vec%0d", i), tbl[i].e_srdy, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_data);
    end

    // num_items=0 gives an immediate done with no valid
    apply(0, 1, 0, 8'hFF, 1);  chk_out("zero.done", 0, 0, 1, 8'h05);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("zero.idle", 0, 0, 0, 8'h05);
    // start during RUN is ignored: still exactly 3 words
    apply(0, 1, 3, 8'hFF, 1);  chk_out("ign.c0", 1, 1, 0, 8'h05);
    apply(0, 1, 9, 8'hFF, 1);  chk_out("ign.c1", 1, 1, 0, 8'h06);
    apply(0, 1, 9, 8'hFF, 1);  chk_out("ign.c2", 1, 1, 0, 8'h07);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("ign.done", 0, 0, 1, 8'h08);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("ign.idle", 0, 0, 0, 8'h08);

    // Back-pressure: word held stable for 5 stalled cycles
    apply(1, 0, 0, 8'hFF, 1);  chk_out("stall.rst", 0, 0, 0, 8'h00);
    apply(0, 1, 2, 8'hFF, 0);  chk_out("stall.start", 1, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 8'hFF, 0);
      chk_out($sformatf("stall.hold%0d", i), 1, 1, 0, 8'h00);
    end
    apply(0, 0, 0, 8'hFF, 1);  chk_out("stall.x0", 1, 1, 0, 8'h01);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("stall.done", 0, 0, 1, 8'h02);

    // Reset mid-run (with start and xfer in the same cycle) abandons the run
    apply(0, 0, 0, 8'hFF, 1);  chk_out("rst.idle", 0, 0, 0, 8'h02);
    apply(1, 0, 0, 8'hFF, 1);
    apply(0, 1, 10, 8'hFF, 1); chk_out("rst.c0", 1, 1, 0, 8'h00);
    apply(0, 0, 0, 8'hFF, 1);
    apply(0, 0, 0, 8'hFF, 1);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("rst.c3", 1, 1, 0, 8'h03);
    apply(1, 1, 5, 8'hFF, 1);  chk_out("rst.hit", 0, 0, 0, 8'h00);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("rst.nodone", 0, 0, 0, 8'h00);
    apply(0, 1, 2, 8'hFF, 1);  chk_out("rst.r0", 1, 1, 0, 8'h00);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("rst.r1", 1, 1, 0, 8'h01);
    apply(0, 0, 0, 8'hFF, 1);  chk_out("rst.rdone", 0, 0, 1, 8'h02);

    // Tagged instance: 130 words wrap the 7-bit seq while tag bit stays set
    t_start = 1'b1; t_num_items = 16'd130; t_srdy_pat = 8'hFF; t_p_drdy = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    k = 0;
    done_cnt = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (t_done) begin
        done_cnt++;
        break;
      end
      if (t_p_srdy && t_p_drdy) begin
        chk($sformatf("tag.word%0d", k), 32'(t_p_data), 32'(8'h80 | 8'(k % 128)));
        k++;
      end
      @(negedge clk);
    end
    chk("tag.count", 32'(k), 32'd130);
    chk("tag.done_seen", 32'(done_cnt), 32'd1);
    chk("tag.last_data", 32'(t_p_data), 32'h82);
    @(negedge clk);
    chk("tag.idle_done", 32'(t_done), 32'd0);
    chk("tag.idle_busy", 32'(t_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
